line_cache: RTL and testbench

//  Direct-mapped, write-through, no-write-allocate cache between one CPU port (I or D) and one line port of
//  the 4-word-line main memory. Read hits return in the request cycle. Misses fetch a 4-word line, holding

---
 rtl/line_cache_pkg.sv | 34 +++
 rtl/line_cache_array.sv | 48 ++++
 rtl/line_cache.sv | 151 +++++++++++++++
 tb/tb_line_cache.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/line_cache_pkg.sv
// Shared widths, address layout and FSM encoding for the line cache.
package line_cache_pkg;

  localparam int unsigned WORD_SIZE   = 16;
  localparam int unsigned LINE_WORDS  = 4;
  localparam int unsigned LINE_SIZE   = WORD_SIZE * LINE_WORDS;
  localparam int unsigned NUM_LINES   = 4;
  localparam int unsigned MEM_LATENCY = 6;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned OFF_W  = $clog2(LINE_WORDS);
  localparam int unsigned IDX_W  = $clog2(NUM_LINES);
  localparam int unsigned TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int unsigned CNT_W  = $clog2(MEM_LATENCY);

  // CPU word address split into tag / line index / word offset
  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] idx;
    logic [OFF_W-1:0] off;
  } addr_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  // Address of word 0 of the line holding a
  function automatic logic [ADDR_W-1:0] line_base(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:OFF_W], OFF_W'(0)};
  endfunction

endpackage

// File: rtl/line_cache_array.sv
// Valid/tag/data storage for the direct-mapped cache with a combinational lookup port.
module line_cache_array
  import line_cache_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  addr_t                lk_addr,
  output logic                 hit_c,
  output logic [WORD_SIZE-1:0] word_c,
  input  logic                 fill_en,
  input  logic [IDX_W-1:0]     fill_idx,
  input  logic [TAG_W-1:0]     fill_tag,
  input  logic [LINE_SIZE-1:0] fill_line,
  input  logic                 wr_en,
  input  logic [IDX_W-1:0]     wr_idx,
  input  logic [OFF_W-1:0]     wr_off,
  input  logic [WORD_SIZE-1:0] wr_word
);

  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [WORD_SIZE-1:0] data_q [NUM_LINES][LINE_WORDS];

  assign hit_c  = valid_q[lk_addr.idx] && (tag_q[lk_addr.idx] == lk_addr.tag);
  assign word_c = data_q[lk_addr.idx][lk_addr.off];

  // Valid bits: cleared by reset, set by a completed line fill
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
    end else if (fill_en) begin
      valid_q[fill_idx] <= 1'b1;
    end
  end

  // Tag/data: whole-line fill (word 0 in the top bits) or single-word write hit
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[fill_idx] <= fill_tag;
      for (int w = 0; w < int'(LINE_WORDS); w++) begin
        data_q[fill_idx][w] <= fill_line[(int'(LINE_WORDS) - 1 - w) * int'(WORD_SIZE) +: WORD_SIZE];
      end
    end else if (wr_en) begin
      data_q[wr_idx][wr_off] <= wr_word;
    end
  end

endmodule

// File: rtl/line_cache.sv
// Direct-mapped, write-through, no-write-allocate cache in front of a 4-word-line memory.
// Optional LINE_CACHE_STATS_EN adds saturating hit_count / miss_count outputs.
module line_cache
  import line_cache_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 c_readC,
  input  logic                 c_writeC,
  input  logic [ADDR_W-1:0]    c_address,
  inout  wire  [WORD_SIZE-1:0] c_data,
  output logic                 c_ready,
  output logic                 m_readM,
  output logic                 m_writeM,
  output logic [ADDR_W-1:0]    m_address,
  inout  wire  [LINE_SIZE-1:0] m_data
`ifdef LINE_CACHE_STATS_EN
  ,
  output logic [15:0]          hit_count,
  output logic [15:0]          miss_count
`endif
);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 m_read_d, m_write_d;
  logic [ADDR_W-1:0]    m_addr_d;
  logic [WORD_SIZE-1:0] wdata_q, wdata_d;
  logic                 fill_en_c, wr_en_c, hit_c;
  logic [WORD_SIZE-1:0] rd_word_c;
  logic                 last_c;
  addr_t                cpu_addr;

  assign cpu_addr = addr_t'(c_address);
  assign last_c   = (cnt_q == CNT_W'(MEM_LATENCY - 1));

  line_cache_array u_array (
    .clk       (clk),
    .reset_n   (reset_n),
    .lk_addr   (cpu_addr),
    .hit_c     (hit_c),
    .word_c    (rd_word_c),
    .fill_en   (fill_en_c),
    .fill_idx  (m_address[OFF_W +: IDX_W]),
    .fill_tag  (m_address[ADDR_W-1 -: TAG_W]),
    .fill_line (m_data),
    .wr_en     (wr_en_c),
    .wr_idx    (cpu_addr.idx),
    .wr_off    (cpu_addr.off),
    .wr_word   (c_data)
  );

  // Cache drives the CPU bus only for a completed read; memory bus only while writing
  assign c_data = (c_readC && !c_writeC && c_ready) ? rd_word_c : {WORD_SIZE{1'bz}};
  assign m_data = m_writeM ? {wdata_q, {(LINE_SIZE - WORD_SIZE){1'b0}}} : {LINE_SIZE{1'bz}};

  // State, counter and registered memory-side outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      m_readM   <= 1'b0;
      m_writeM  <= 1'b0;
      m_address <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      m_readM   <= m_read_d;
      m_writeM  <= m_write_d;
      m_address <= m_addr_d;
      wdata_q   <= wdata_d;
    end
  end

  // Next state, memory sequencing and CPU handshake
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    m_read_d  = 1'b0;
    m_write_d = 1'b0;
    m_addr_d  = m_address;
    wdata_d   = wdata_q;
    fill_en_c = 1'b0;
    wr_en_c   = 1'b0;
    c_ready   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (c_writeC) begin
          // Write wins over a simultaneous read; a hit updates the cached copy now
          state_d   = ST_WRITE;
          m_write_d = 1'b1;
          m_addr_d  = c_address;
          wdata_d   = c_data;
          wr_en_c   = hit_c;
        end else if (c_readC) begin
          if (hit_c) begin
            c_ready = 1'b1;
          end else begin
            state_d  = ST_FETCH;
            m_read_d = 1'b1;
            m_addr_d = line_base(c_address);
          end
        end
      end
      ST_FETCH: begin
        if (last_c) begin
          fill_en_c = 1'b1;
          state_d   = ST_IDLE;
          cnt_d     = '0;
        end else begin
          m_read_d = 1'b1;
          cnt_d    = cnt_q + CNT_W'(1);
        end
      end
      ST_WRITE: begin
        if (last_c) begin
          c_ready = c_readC || c_writeC;
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          m_write_d = 1'b1;
          cnt_d     = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

`ifdef LINE_CACHE_STATS_EN
  // Saturating counts of read hits and of line fetches started
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (state_q == ST_IDLE && c_ready && hit_count != 16'hFFFF) begin
        hit_count <= hit_count + 16'd1;
      end
      if (state_q == ST_IDLE && state_d == ST_FETCH && miss_count != 16'hFFFF) begin
        miss_count <= miss_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_line_cache.sv
// Directed bench for line_cache: table of CPU transactions plus reset and mid-fetch sequences.
module tb_line_cache;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        c_readC = 1'b0;
  logic        c_writeC = 1'b0;
  logic [15:0] c_address = 16'h0000;
  logic [15:0] tb_cdata = 16'h0000;
  wire  [15:0] c_data;
  logic        c_ready;
  logic        m_readM;
  logic        m_writeM;
  logic [15:0] m_address;
  wire  [63:0] m_data;
  logic [63:0] mem_line;
  logic [15:0] mem [0:65535];
`ifdef LINE_CACHE_STATS_EN
  logic [15:0] hit_count, miss_count;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  line_cache dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .c_readC   (c_readC),
    .c_writeC  (c_writeC),
    .c_address (c_address),
    .c_data    (c_data),
    .c_ready   (c_ready),
    .m_readM   (m_readM),
    .m_writeM  (m_writeM),
    .m_address (m_address),
    .m_data    (m_data)
`ifdef LINE_CACHE_STATS_EN
    ,
    .hit_count (hit_count),
    .miss_count(miss_count)
`endif
  );

  // CPU drives data on writes; memory returns the addressed line on reads
  assign c_data = c_writeC ? tb_cdata : 16'bz;
  always_comb mem_line = {mem[{m_address[15:2], 2'd0}], mem[{m_address[15:2], 2'd1}],
                          mem[{m_address[15:2], 2'd2}], mem[{m_address[15:2], 2'd3}]};
  assign m_data = m_readM ? mem_line : 64'bz;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_data;
    int          exp_lat;
    int          exp_nrd;
    int          exp_nwr;
    logic [15:0] exp_maddr;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // One CPU request held until c_ready (bounded); optionally retarget address mid-op
  task automatic do_txn(input logic rd, input logic wr, input logic [15:0] addr,
                        input logic [15:0] wdata, input logic [15:0] exp_maddr,
                        input int sw_cyc, input logic [15:0] sw_addr,
                        output int lat, output logic [15:0] rdata, output int nrd,
                        output int nwr, output int bad_maddr, output logic [15:0] mwd);
    lat = -1; rdata = 16'hxxxx; nrd = 0; nwr = 0; bad_maddr = 0; mwd = 16'hxxxx;
    @(negedge clk);
    c_readC = rd; c_writeC = wr; c_address = addr; tb_cdata = wdata;
    for (int k = 0; k < 20; k++) begin
      if (k == sw_cyc) c_address = sw_addr;
      #1;
      if (m_readM) nrd++;
      if (m_writeM) begin
        nwr++;
        mwd = m_data[63:48];
        mem[m_address] = m_data[63:48];
      end
      if ((m_readM || m_writeM) && m_address !== exp_maddr) bad_maddr++;
      if (c_ready === 1'b1) begin
        lat = k;
        rdata = c_data;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    c_readC = 1'b0; c_writeC = 1'b0;
  endtask

  initial begin
    int          lat, nrd, nwr, bad;
    logic [15:0] rdata, mwd;

    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    mem[16'h0023] = 16'h6000;
    mem[16'h0024] = 16'hf01c;
    mem[16'h0025] = 16'h1111;
    mem[16'h0030] = 16'hf41c;
    mem[16'h0031] = 16'h2222;
    mem[16'h0045] = 16'h4545;

    //            rd    wr    addr      wdata     exp_data  lat np nw  maddr
    vecs[0]  = '{1'b1, 1'b0, 16'h0023, 16'h0000, 16'h6000, 7, 6, 0, 16'h0020};
    vecs[1]  = '{1'b1, 1'b0, 16'h0023, 16'h0000, 16'h6000, 0, 0, 0, 16'h0000};
    vecs[2]  = '{1'b1, 1'b0, 16'h0024, 16'h0000, 16'hf01c, 7, 6, 0, 16'h0024};
    vecs[3]  = '{1'b1, 1'b0, 16'h0025, 16'h0000, 16'h1111, 0, 0, 0, 16'h0000};
    vecs[4]  = '{1'b1, 1'b0, 16'h0020, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000};
    vecs[5]  = '{1'b0, 1'b1, 16'h0021, 16'h1234, 16'h0000, 6, 0, 6, 16'h0021};
    vecs[6]  = '{1'b1, 1'b0, 16'h0021, 16'h0000, 16'h1234, 0, 0, 0, 16'h0000};
    vecs[7]  = '{1'b1, 1'b0, 16'h0030, 16'h0000, 16'hf41c, 7, 6, 0, 16'h0030};
    vecs[8]  = '{1'b1, 1'b0, 16'h0031, 16'h0000, 16'h2222, 0, 0, 0, 16'h0000};
    vecs[9]  = '{1'b1, 1'b0, 16'h0023, 16'h0000, 16'h6000, 7, 6, 0, 16'h0020};
    vecs[10] = '{1'b1, 1'b0, 16'h0021, 16'h0000, 16'h1234, 0, 0, 0, 16'h0000};
    vecs[11] = '{1'b0, 1'b1, 16'h0035, 16'habcd, 16'h0000, 6, 0, 6, 16'h0035};
    vecs[12] = '{1'b1, 1'b0, 16'h0035, 16'h0000, 16'habcd, 7, 6, 0, 16'h0034};
    vecs[13] = '{1'b1, 1'b1, 16'h0022, 16'h5555, 16'h0000, 6, 0, 6, 16'h0022};
    vecs[14] = '{1'b1, 1'b0, 16'h0022, 16'h0000, 16'h5555, 0, 0, 0, 16'h0000};

    // Power-on reset
    #2 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset m_readM", 32'(m_readM), 32'h0);
    chk("reset m_writeM", 32'(m_writeM), 32'h0);
    chk("reset m_address", 32'(m_address), 32'h0);
    chk("reset c_ready", 32'(c_ready), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // Table of transactions
    for (int i = 0; i < 15; i++) begin
      do_txn(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp_maddr,
             -1, 16'h0000, lat, rdata, nrd, nwr, bad, mwd);
      chk($sformatf("v%0d latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      chk($sformatf("v%0d m_readM cycles", i), 32'(nrd), 32'(vecs[i].exp_nrd));
      chk($sformatf("v%0d m_writeM cycles", i), 32'(nwr), 32'(vecs[i].exp_nwr));
      chk($sformatf("v%0d m_address off-target cycles", i), 32'(bad), 32'h0);
      if (vecs[i].rd && !vecs[i].wr)
        chk($sformatf("v%0d c_data", i), 32'(rdata), 32'(vecs[i].exp_data));
      if (vecs[i].wr)
        chk($sformatf("v%0d m_data word", i), 32'(mwd), 32'(vecs[i].wdata));
    end

    // Address changes mid-fetch: 0x44 line still filled, then 0x23 served as a hit
    do_txn(1'b1, 1'b0, 16'h0044, 16'h0000, 16'h0044, 2, 16'h0023,
           lat, rdata, nrd, nwr, bad, mwd);
    chk("switch latency", 32'(lat), 32'd7);
    chk("switch m_readM cycles", 32'(nrd), 32'd6);
    chk("switch m_address held", 32'(bad), 32'h0);
    chk("switch c_data", 32'(rdata), 32'h6000);
    do_txn(1'b1, 1'b0, 16'h0045, 16'h0000, 16'h0000, -1, 16'h0000,
           lat, rdata, nrd, nwr, bad, mwd);
    chk("switch fill latency", 32'(lat), 32'd0);
    chk("switch fill c_data", 32'(rdata), 32'h4545);

    // Reset three cycles into a fetch
    @(negedge clk);
    c_readC = 1'b1; c_address = 16'h0040;
    repeat (3) @(negedge clk);
    #1;
    chk("pre-reset m_readM", 32'(m_readM), 32'h1);
    reset_n = 1'b0;
    #1;
    chk("async reset m_readM", 32'(m_readM), 32'h0);
    chk("async reset m_address", 32'(m_address), 32'h0);
    chk("async reset c_ready", 32'(c_ready), 32'h0);
    repeat (3) @(negedge clk);
    c_readC = 1'b0;
    reset_n = 1'b1;
    do_txn(1'b1, 1'b0, 16'h0023, 16'h0000, 16'h0020, -1, 16'h0000,
           lat, rdata, nrd, nwr, bad, mwd);
    chk("post-reset latency", 32'(lat), 32'd7);
    chk("post-reset m_readM cycles", 32'(nrd), 32'd6);
    chk("post-reset m_address", 32'(bad), 32'h0);
    chk("post-reset c_data", 32'(rdata), 32'h6000);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
